// File: rtl/mand_seq.sv
// Bus-initiator sequencer for the Mandelbrot iteration unit: clears a per-point escape-count RAM,
// then runs MAXPASS trigger/readback passes and records the first pass at which each point escaped.
module mand_seq #(
  parameter int unsigned NPOINTS = 16384,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [15:0] s_address,
  input  logic [31:0] s_data_in,
  output logic [31:0] s_data_out,
  output logic        s_wait_out,
  output logic        m_read,
  output logic        m_write,
  output logic [15:0] m_address,
  output logic [31:0] m_data_out,
  output logic [3:0]  m_be,
  input  logic [31:0] m_data_in,
  input  logic        m_wait_in,
  output logic        irq
);

  localparam int unsigned IdxW = $clog2(NPOINTS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NPOINTS - 1);

  typedef enum logic [2:0] {
    StIdle, StClear, StTrig, StScanX, StScanY, StEval, StNext, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  maxpass_q, maxpass_d;
  logic              done_q, done_d;
  logic [7:0]        xexp_q, xexp_d;
  logic [7:0]        yexp_q, yexp_d;
  logic              host_rd_q;
  logic              host_rd_d;

  logic [CNT_W-1:0]  count_mem [NPOINTS];
  logic [CNT_W-1:0]  cnt_rd_q;
  logic [CNT_W-1:0]  host_data_q;
  logic              ram_we;
  logic [CNT_W-1:0]  ram_wdata;

  logic start, busy, last_idx, escape, host_req;
  logic unused_bits;

  assign start    = s_write && (s_address == 16'h0000) && s_data_in[0];
  assign busy     = (state_q != StIdle);
  assign last_idx = (idx_q == LastIdx);
  // Exponent field >= 128 means |v| >= 2.0; inf and NaN land there too.
  assign escape   = (xexp_q >= 8'h80) || (yexp_q >= 8'h80);
  assign host_req = s_read && s_address[15];
  assign irq      = done_q;

  assign unused_bits = ^{s_data_in[31:CNT_W], m_data_in[31], m_data_in[22:0]};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    done_d    = done_q;
    xexp_d    = xexp_q;
    yexp_d    = yexp_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          done_d  = 1'b0;
          pass_d  = '0;
          idx_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        ram_we = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (last_idx) begin
          state_d = (maxpass_q == '0) ? StDone : StTrig;
        end
      end
      StTrig: begin
        if (!m_wait_in) begin
          pass_d  = pass_q + 1'b1;
          idx_d   = '0;
          state_d = StScanX;
        end
      end
      StScanX: begin
        if (!m_wait_in) begin
          xexp_d  = m_data_in[30:23];
          state_d = StScanY;
        end
      end
      StScanY: begin
        if (!m_wait_in) begin
          yexp_d  = m_data_in[30:23];
          state_d = StEval;
        end
      end
      StEval: begin
        if ((cnt_rd_q == '0) && escape) begin
          ram_we    = 1'b1;
          ram_wdata = pass_q;
        end
        state_d = StNext;
      end
      StNext: begin
        if (last_idx) begin
          // >= keeps a MAXPASS lowered mid-run from spinning past it.
          state_d = (pass_q >= maxpass_q) ? StDone : StTrig;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StScanX;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    maxpass_d = maxpass_q;
    if (s_write && (s_address == 16'h0001)) begin
      maxpass_d = s_data_in[CNT_W-1:0];
    end
  end

  assign host_rd_d  = host_req && !host_rd_q;
  assign s_wait_out = host_req && !host_rd_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pass_q    <= '0;
      maxpass_q <= '0;
      done_q    <= 1'b0;
      xexp_q    <= '0;
      yexp_q    <= '0;
      host_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      maxpass_q <= maxpass_d;
      done_q    <= done_d;
      xexp_q    <= xexp_d;
      yexp_q    <= yexp_d;
      host_rd_q <= host_rd_d;
    end
  end

  // Internal read/write port and host read-only port; no reset on storage.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      count_mem[idx_q] <= ram_wdata;
    end
    if (state_q == StScanX) begin
      cnt_rd_q <= count_mem[idx_q];
    end
    if (host_req && !host_rd_q) begin
      host_data_q <= count_mem[s_address[IdxW-1:0]];
    end
  end

  always_comb begin
    s_data_out = '0;
    if (s_read) begin
      if (s_address[15]) begin
        if (host_rd_q) begin
          s_data_out = 32'(host_data_q);
        end
      end else begin
        case (s_address)
          16'h0000: s_data_out = {30'b0, done_q, busy};
          16'h0001: s_data_out = 32'(maxpass_q);
          16'h0002: s_data_out = 32'(pass_q);
          default:  s_data_out = '0;
        endcase
      end
    end
  end

  always_comb begin
    m_read     = (state_q == StScanX) || (state_q == StScanY);
    m_write    = (state_q == StTrig);
    m_data_out = '0;
    m_be       = (m_read || m_write) ? 4'hF : 4'h0;
    m_address  = '0;
    case (state_q)
      StTrig:  m_address = 16'hFFFC;
      StScanX: m_address = 16'h8000 | 16'(idx_q);
      StScanY: m_address = 16'hC000 | 16'(idx_q);
      default: m_address = '0;
    endcase
  end

endmodule

// File: tb/tb_mand_seq.sv
// Self-checking bench for mand_seq with a reduced frame size, a stalling slave model and a
// first-escape-pass reference model.
module tb_mand_seq;

  localparam int N  = 64;
  localparam int IW = $clog2(N);

  logic        clock;
  logic        rst_n;
  logic        s_read, s_write;
  logic [15:0] s_address;
  logic [31:0] s_data_in, s_data_out;
  logic        s_wait_out;
  logic        m_read, m_write;
  logic [15:0] m_address;
  logic [31:0] m_data_out;
  logic [3:0]  m_be;
  logic [31:0] m_data_in;
  logic        m_wait_in;
  logic        irq;

  mand_seq #(.NPOINTS(N), .CNT_W(8)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .s_read     (s_read),
    .s_write    (s_write),
    .s_address  (s_address),
    .s_data_in  (s_data_in),
    .s_data_out (s_data_out),
    .s_wait_out (s_wait_out),
    .m_read     (m_read),
    .m_write    (m_write),
    .m_address  (m_address),
    .m_data_out (m_data_out),
    .m_be       (m_be),
    .m_data_in  (m_data_in),
    .m_wait_in  (m_wait_in),
    .irq        (irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Per-pass slave results, index [pass][point]; pass 0 unused.
  logic [31:0] xv [0:7][0:N-1];
  logic [31:0] yv [0:7][0:N-1];
  logic [31:0] ram_got [0:N-1];
  logic [31:0] ram_save [0:N-1];
  int          ram_wait_bad;

  int  cfg_trig_stall = 0;
  int  cfg_rd_stall   = 0;
  bit  slv_clr        = 0;
  int  trig_cnt, n_rd, n_wr, n_unstable, n_badaddr, stall_left;
  bit  waiting;
  logic [15:0] held_addr;
  logic        held_rd, held_wr;

  // Slave: decides stall/complete at each negedge for the following rising edge.
  always @(negedge clock) begin
    if (slv_clr) begin
      trig_cnt = 0; n_rd = 0; n_wr = 0; n_unstable = 0; n_badaddr = 0; waiting = 0;
    end
    if (m_read || m_write) begin
      if (!waiting) begin
        waiting    = 1;
        held_addr  = m_address;
        held_rd    = m_read;
        held_wr    = m_write;
        stall_left = m_write ? cfg_trig_stall : cfg_rd_stall;
      end else if (m_address !== held_addr || m_read !== held_rd || m_write !== held_wr) begin
        n_unstable++;
      end
      if (m_be !== 4'hF || m_data_out !== 32'h0 || (m_read && m_write)) n_unstable++;
      if (stall_left > 0) begin
        m_wait_in = 1'b1;
        m_data_in = 32'hDEADBEEF;
        stall_left--;
      end else begin
        m_wait_in = 1'b0;
        waiting   = 0;
        if (m_write) begin
          n_wr++;
          if (m_address !== 16'hFFFC) n_badaddr++;
          trig_cnt++;
          m_data_in = 32'h0;
        end else begin
          n_rd++;
          if (m_address[13:IW] !== '0 || m_address[15] !== 1'b1 || trig_cnt > 7) begin
            n_badaddr++;
            m_data_in = 32'h0;
          end else if (m_address[14]) begin
            m_data_in = yv[trig_cnt][m_address[IW-1:0]];
          end else begin
            m_data_in = xv[trig_cnt][m_address[IW-1:0]];
          end
        end
      end
    end else begin
      waiting   = 0;
      m_wait_in = 1'b0;
      m_data_in = 32'h0;
      if (m_be !== 4'h0) n_unstable++;
    end
  end

  // Reference: |v| >= 2.0 (or inf/NaN) iff the biased exponent is at least 128.
  function automatic bit esc(input logic [31:0] v);
    int e;
    e = int'(v[30:23]);
    return e >= 128;
  endfunction

  function automatic int ref_count(input int i, input int maxp);
    for (int p = 1; p <= maxp; p++) begin
      if (esc(xv[p][i]) || esc(yv[p][i])) return p;
    end
    return 0;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 11))
      0:       return 32'h40000000;
      1:       return 32'hC0000000;
      2:       return 32'h7F800000;
      3:       return 32'h7FC00001;
      4:       return 32'h40490FDB;
      5:       return 32'h3FFFFFFF;
      6:       return 32'hBFFFFFFF;
      7:       return {1'b0, 8'h7F, 23'($urandom)};
      8:       return {1'b1, 8'h7E, 23'($urandom)};
      default: return 32'h00000000;
    endcase
  endfunction

  task automatic fill_const();
    for (int p = 0; p < 8; p++)
      for (int i = 0; i < N; i++) begin
        xv[p][i] = 32'h3F800000;
        yv[p][i] = 32'h00000000;
      end
  endtask

  task automatic fill_random();
    for (int p = 0; p < 8; p++)
      for (int i = 0; i < N; i++) begin
        // Bias toward non-escaping values so first-escape passes spread out.
        xv[p][i] = ($urandom_range(0, 2) == 0) ? rand_val() : 32'h3F000000;
        yv[p][i] = ($urandom_range(0, 2) == 0) ? rand_val() : 32'hBF000000;
      end
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clock);
    s_write = 1'b1; s_address = a; s_data_in = d;
    @(negedge clock);
    s_write = 1'b0; s_data_in = '0; s_address = '0;
  endtask

  task automatic host_read_reg(input logic [15:0] a, output logic [31:0] d);
    @(negedge clock);
    s_read = 1'b1; s_address = a;
    #1 d = s_data_out;
    @(negedge clock);
    s_read = 1'b0; s_address = '0;
  endtask

  task automatic read_all();
    logic w1, w2;
    ram_wait_bad = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clock);
      s_read = 1'b1; s_address = 16'h8000 | 16'(i);
      #1 w1 = s_wait_out;
      @(negedge clock);
      #1 w2 = s_wait_out;
      ram_got[i] = s_data_out;
      @(negedge clock);
      s_read = 1'b0; s_address = '0;
      if (w1 !== 1'b1 || w2 !== 1'b0) ram_wait_bad++;
    end
  endtask

  task automatic slave_clear();
    slv_clr = 1;
    @(negedge clock);
    @(negedge clock);
    slv_clr = 0;
  endtask

  // Counts busy cycles starting at the negedge right after the accepting edge.
  task automatic wait_done(output int cycles, output bit to);
    s_read = 1'b1; s_address = 16'h0000; cycles = 0; to = 1;
    for (int k = 0; k < 30000; k++) begin
      #1;
      if (s_data_out[0] === 1'b0) begin
        to = 0;
        break;
      end
      cycles++;
      @(negedge clock);
    end
    s_read = 1'b0;
  endtask

  task automatic run_frame(input int maxp, output int cycles, output bit to);
    host_write(16'h0001, 32'(maxp));
    slave_clear();
    host_write(16'h0000, 32'h1);
    wait_done(cycles, to);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_checks++;
    if ({m_read, m_write, m_be, irq, s_wait_out} !== 8'h0) begin
      n_errors++;
      $display("FAIL reset_strobes: got %b expected 0", {m_read, m_write, m_be, irq, s_wait_out});
    end
    n_checks++;
    if (m_address !== 16'h0 || m_data_out !== 32'h0 || s_data_out !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_buses: got addr %h mdo %h sdo %h expected 0",
               m_address, m_data_out, s_data_out);
    end
    host_read_reg(16'h0000, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    host_read_reg(16'h0002, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL reset_pass: got %h expected 0", d); end
    host_read_reg(16'h0001, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL reset_maxpass: got %h expected 0", d); end
  endtask

  task automatic check_ram(input string name, input int maxp);
    read_all();
    n_checks++;
    if (ram_wait_bad !== 0) begin
      n_errors++;
      $display("FAIL %s_ram_wait: got %0d bad reads expected 0", name, ram_wait_bad);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (ram_got[i] !== 32'(ref_count(i, maxp))) begin
        n_errors++;
        $display("FAIL %s_count[%0d]: got %0d expected %0d", name, i, ram_got[i],
                 ref_count(i, maxp));
      end
    end
  endtask

  task automatic test_single_pass();
    int cyc; bit to;
    fill_const();
    xv[1][5] = 32'h40000000;
    run_frame(1, cyc, to);
    n_checks++;
    if (to || cyc !== N + 1 + 4 * N + 1) begin
      n_errors++;
      $display("FAIL single_cycles: got %0d (timeout %0d) expected %0d", cyc, to, 5 * N + 2);
    end
    n_checks++;
    if (n_wr !== 1 || n_rd !== 2 * N || n_badaddr !== 0 || n_unstable !== 0) begin
      n_errors++;
      $display("FAIL single_bus: got wr %0d rd %0d bad %0d unst %0d expected 1 %0d 0 0",
               n_wr, n_rd, n_badaddr, n_unstable, 2 * N);
    end
    check_ram("single", 1);
    n_checks++;
    if (ram_got[5] !== 32'd1) begin
      n_errors++;
      $display("FAIL single_idx5: got %0d expected 1", ram_got[5]);
    end
  endtask

  task automatic test_no_overwrite();
    int cyc; bit to; logic [31:0] d;
    fill_const();
    yv[2][7] = 32'hC0000000;
    yv[3][7] = 32'hC0000000;
    run_frame(3, cyc, to);
    n_checks++;
    if (to || n_wr !== 3) begin
      n_errors++;
      $display("FAIL noovw_trig: got %0d (timeout %0d) expected 3", n_wr, to);
    end
    host_read_reg(16'h0002, d);
    n_checks++;
    if (d !== 32'd3) begin n_errors++; $display("FAIL noovw_pass: got %0d expected 3", d); end
    check_ram("noovw", 3);
    n_checks++;
    if (ram_got[7] !== 32'd2) begin
      n_errors++;
      $display("FAIL noovw_idx7: got %0d expected 2", ram_got[7]);
    end
  endtask

  task automatic test_random();
    int cyc; bit to; int maxp;
    for (int it = 0; it < 2; it++) begin
      fill_random();
      maxp = $urandom_range(1, 3);
      run_frame(maxp, cyc, to);
      n_checks++;
      if (to || cyc !== N + maxp * (1 + 4 * N) + 1) begin
        n_errors++;
        $display("FAIL random_cycles: got %0d (timeout %0d) expected %0d", cyc, to,
                 N + maxp * (1 + 4 * N) + 1);
      end
      n_checks++;
      if (n_wr !== maxp || n_rd !== 2 * N * maxp || n_unstable !== 0 || n_badaddr !== 0) begin
        n_errors++;
        $display("FAIL random_bus: got wr %0d rd %0d unst %0d bad %0d expected %0d %0d 0 0",
                 n_wr, n_rd, n_unstable, n_badaddr, maxp, 2 * N * maxp);
      end
      check_ram("random", maxp);
    end
  endtask

  task automatic test_clear_only();
    int cyc; bit to; logic [31:0] d;
    run_frame(0, cyc, to);
    n_checks++;
    if (to || cyc !== N + 1) begin
      n_errors++;
      $display("FAIL clear_cycles: got %0d (timeout %0d) expected %0d", cyc, to, N + 1);
    end
    n_checks++;
    if (n_rd !== 0 || n_wr !== 0) begin
      n_errors++;
      $display("FAIL clear_bus: got rd %0d wr %0d expected 0 0", n_rd, n_wr);
    end
    host_read_reg(16'h0000, d);
    n_checks++;
    if (d !== 32'h2) begin n_errors++; $display("FAIL clear_ctrl: got %h expected 2", d); end
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL clear_irq: got %b expected 1", irq); end
    check_ram("clear", 0);
  endtask

  task automatic test_wait_states();
    int cyc; bit to;
    fill_random();
    run_frame(2, cyc, to);
    read_all();
    for (int i = 0; i < N; i++) ram_save[i] = ram_got[i];
    cfg_trig_stall = 50;
    cfg_rd_stall   = 3;
    run_frame(2, cyc, to);
    cfg_trig_stall = 0;
    cfg_rd_stall   = 0;
    n_checks++;
    if (to || cyc !== N + 2 * (51 + 10 * N) + 1) begin
      n_errors++;
      $display("FAIL wait_cycles: got %0d (timeout %0d) expected %0d", cyc, to,
               N + 2 * (51 + 10 * N) + 1);
    end
    n_checks++;
    if (n_unstable !== 0 || n_wr !== 2 || n_rd !== 4 * N) begin
      n_errors++;
      $display("FAIL wait_bus: got unst %0d wr %0d rd %0d expected 0 2 %0d",
               n_unstable, n_wr, n_rd, 4 * N);
    end
    check_ram("wait", 2);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (ram_got[i] !== ram_save[i]) begin
        n_errors++;
        $display("FAIL wait_vs_zero[%0d]: got %0d expected %0d", i, ram_got[i], ram_save[i]);
      end
    end
  endtask

  task automatic test_busy_start();
    int cyc; bit to;
    fill_random();
    host_write(16'h0001, 32'd2);
    slave_clear();
    host_write(16'h0000, 32'h1);
    repeat (100) @(negedge clock);
    host_write(16'h0000, 32'h1);
    wait_done(cyc, to);
    n_checks++;
    if (to || cyc + 102 !== N + 2 * (1 + 4 * N) + 1) begin
      n_errors++;
      $display("FAIL busy_cycles: got %0d (timeout %0d) expected %0d", cyc + 102, to,
               N + 2 * (1 + 4 * N) + 1);
    end
    n_checks++;
    if (n_wr !== 2) begin n_errors++; $display("FAIL busy_trig: got %0d expected 2", n_wr); end
    check_ram("busy", 2);
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; bit found; logic [31:0] d;
    fill_random();
    cfg_rd_stall = 3;
    host_write(16'h0001, 32'd2);
    slave_clear();
    host_write(16'h0000, 32'h1);
    found = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clock);
      #1;
      if (m_read === 1'b1 && m_address[15:14] === 2'b11 && m_address[IW-1:0] == 3) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL rstmid_scany: got none expected scan_y"); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_read !== 1'b0 || m_write !== 1'b0 || m_be !== 4'h0) begin
      n_errors++;
      $display("FAIL rstmid_strobes: got rd %b wr %b be %h expected 0", m_read, m_write, m_be);
    end
    @(negedge clock);
    rst_n = 1'b1;
    cfg_rd_stall = 0;
    host_read_reg(16'h0000, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL rstmid_ctrl: got %h expected 0", d); end
    run_frame(2, cyc, to);
    n_checks++;
    if (to || cyc !== N + 2 * (1 + 4 * N) + 1) begin
      n_errors++;
      $display("FAIL rstmid_cycles: got %0d (timeout %0d) expected %0d", cyc, to,
               N + 2 * (1 + 4 * N) + 1);
    end
    check_ram("rstmid", 2);
  endtask

  initial begin
    rst_n = 1'b0;
    s_read = 1'b0; s_write = 1'b0; s_address = '0; s_data_in = '0;
    fill_const();
    repeat (3) @(negedge clock);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_reset();
    test_single_pass();
    test_no_overwrite();
    test_random();
    test_clear_only();
    test_wait_states();
    test_busy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
